// File: rtl/mul_pkg.sv
// Shared types for the EXU multiply sequencer: op encoding, FSM states and the latched-op record.
package mul_pkg;

   localparam int MUL_XLEN  = 64;
   localparam int MUL_TAG_W = 5;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_MULW   = 3'd4
   } mul_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

   // Only the fields the post-multiply fix-up needs; src0 survives as its sign bit alone.
   typedef struct packed {
      mul_op_e              op;
      logic [MUL_TAG_W-1:0] tag;
      logic                 src0_sign;
      logic [MUL_XLEN-1:0]  src1;
   } mul_lat_t;

   // Reserved encodings 5-7 run as a plain MUL.
   function automatic mul_op_e decode_op(input logic [2:0] code);
      return (code > 3'd4) ? OP_MUL : mul_op_e'(code);
   endfunction

endpackage

// File: rtl/mult_wallace.sv
// Registered WIDTH x WIDTH multiplier; product and vld appear one cycle after req.
// The sign input treats both operands as signed; the vld register is deliberately left unreset.
module mult_wallace #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               req,
   input  logic               sign,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               data_vld,
   output logic [2*WIDTH-1:0] data
);

   logic [2*WIDTH-1:0] a_x, b_x, prod;
   logic               vld_q;
   logic [2*WIDTH-1:0] data_q;

   always_comb begin
      a_x  = {{WIDTH{sign & a[WIDTH-1]}}, a};
      b_x  = {{WIDTH{sign & b[WIDTH-1]}}, b};
      prod = a_x * b_x;
   end

   always_ff @(posedge clk) begin
      vld_q  <= req;
      data_q <= prod;
   end

   assign data_vld = vld_q;
   assign data     = data_q;

endmodule

// File: rtl/mul_unit_ctrl.sv
// RV64M multiply sequencer: accept -> multiplier -> fix-up -> held result, 2-cycle latency.
// in_ready drops while a result is stalled by out_ready or a flush is present; results held until taken.
module mul_unit_ctrl
   import mul_pkg::*;
#(
   parameter int XLEN  = MUL_XLEN,
   parameter int TAG_W = MUL_TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [XLEN-1:0]  in_src0,
   input  logic [XLEN-1:0]  in_src1,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   mul_state_e        state_q, state_d;
   mul_lat_t          lat_q, lat_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic [XLEN-1:0]   fix_res, p_lo, p_hi, hsu_corr;
   logic              accept, mult_sign, mult_data_vld;
   logic [2*XLEN-1:0] mult_data;
   mul_op_e           in_op_dec;

   assign in_op_dec = decode_op(in_op);
   assign in_ready  = !flush && (state_q == ST_IDLE || (state_q == ST_DONE && out_ready));
   assign accept    = in_valid && in_ready;
   // MULHSU runs unsigned and is corrected afterwards; MUL/MULW low bits are sign-agnostic.
   assign mult_sign = !(in_op_dec == OP_MULHU || in_op_dec == OP_MULHSU);

   mult_wallace #(.WIDTH(XLEN)) u_mult (
      .clk      (clk),
      .req      (accept),
      .sign     (mult_sign),
      .a        (in_src0),
      .b        (in_src1),
      .data_vld (mult_data_vld),
      .data     (mult_data)
   );

   always_comb begin
      p_lo     = mult_data[XLEN-1:0];
      p_hi     = mult_data[2*XLEN-1:XLEN];
      hsu_corr = lat_q.src0_sign ? lat_q.src1 : '0;
      case (lat_q.op)
         OP_MULH, OP_MULHU: fix_res = p_hi;
         OP_MULHSU:         fix_res = p_hi - hsu_corr;
         OP_MULW:           fix_res = {{(XLEN-32){p_lo[31]}}, p_lo[31:0]};
         default:           fix_res = p_lo;
      endcase
   end

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      res_d   = res_q;
      if (accept) begin
         lat_d.op        = in_op_dec;
         lat_d.tag       = in_tag;
         lat_d.src0_sign = in_src0[XLEN-1];
         lat_d.src1      = in_src1;
      end
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_WAIT;
         ST_WAIT: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (mult_data_vld) begin
               state_d = ST_DONE;
               res_d   = fix_res;
            end
         end
         ST_DONE: begin
            if (flush)          state_d = ST_IDLE;
            else if (out_ready) state_d = accept ? ST_WAIT : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lat_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         res_q   <= res_d;
      end
   end

   assign out_valid = (state_q == ST_DONE);
   assign out_data  = res_q;
   assign out_tag   = lat_q.tag;
   assign busy      = (state_q != ST_IDLE);

   // The multiplier always answers the cycle after a request; a gap here means it is broken.
   assert property (@(posedge clk) disable iff (!rst_n) (state_q == ST_WAIT) |-> mult_data_vld);

endmodule

// File: tb/tb_mul_unit_ctrl.sv
// Bench for mul_unit_ctrl: directed vector table, random ops against an arithmetic model,
// and hand sequences for stall, back-to-back issue, flush and reset-in-flight.
module tb_mul_unit_ctrl;

   localparam int XLEN  = 64;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [2:0]       in_op;
   logic [XLEN-1:0]  in_src0, in_src1, out_data;
   logic [TAG_W-1:0] in_tag, out_tag;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mul_unit_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_src0   (in_src0),
      .in_src1   (in_src1),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   typedef struct {
      logic [2:0]       op;
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  exp;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Architectural result straight from the RV64M definitions, using full-width products.
   function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
      logic [127:0] p;
      logic [31:0]  w;
      case (op)
         3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
         3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
         3'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
         3'd4: begin w = a[31:0] * b[31:0];                   return {{32{w[31]}}, w}; end
         default: return a * b;
      endcase
   endfunction

   // Issue one op from IDLE, hold out_ready low for 'stall' result cycles, then take it.
   task automatic run_op(input string nm, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAG_W-1:0] tag,
                         input logic [63:0] exp, input int stall);
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_src0 = a; in_src1 = b; in_tag = tag;
      out_ready = (stall == 0);
      #1 chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk({nm, " out_valid@t+1"}, 64'(out_valid), 64'd0);
      for (int s = 0; s <= stall; s++) begin
         @(negedge clk);
         out_ready = (s == stall);
         #1;
         chk({nm, " out_valid"}, 64'(out_valid), 64'd1);
         chk({nm, " out_data"}, out_data, exp);
         chk({nm, " out_tag"}, 64'(out_tag), 64'(tag));
      end
   endtask

   initial begin
      logic [2:0]       r_op;
      logic [63:0]      r_a, r_b;
      logic [TAG_W-1:0] r_tag;

      vecs[0] = '{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9,  64'hFFFF_FFFF_FFFF_FFEB};
      vecs[1] = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1,  64'hFFFF_FFFF_FFFF_FFFF};
      vecs[2] = '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2,  64'd1};
      vecs[3] = '{3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3,  64'hFFFF_FFFF_FFFF_FFFF};
      vecs[4] = '{3'd4, 64'h0000_0000_8000_0000, 64'd1, 5'd4,  64'hFFFF_FFFF_8000_0000};
      vecs[5] = '{3'd5, 64'd3, 64'd4, 5'd31, 64'd12};
      vecs[6] = '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17,
                  64'hFFFF_FFFF_FFFF_FFFE};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_op = '0; in_src0 = '0; in_src1 = '0; in_tag = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst out_data", out_data, 64'd0);
      chk("rst out_tag", 64'(out_tag), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      #1 chk("rst in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 7; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
                vecs[i].exp, 0);

      for (int i = 0; i < 40; i++) begin
         r_op  = 3'($urandom_range(0, 7));
         r_a   = {$urandom, $urandom};
         r_b   = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) r_a = 64'h8000_0000_0000_0000;
         if ($urandom_range(0, 3) == 0) r_b = 64'hFFFF_FFFF_FFFF_FFFF;
         r_tag = TAG_W'($urandom);
         run_op($sformatf("rnd%0d", i), r_op, r_a, r_b, r_tag, ref_mul(r_op, r_a, r_b),
                int'($urandom_range(0, 2)));
      end

      // Stall 5 cycles in DONE, then hand off and accept the next op in the same cycle.
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'd0; in_src0 = 64'd5; in_src1 = 64'd6; in_tag = 5'd3;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'd3; in_src0 = '1; in_src1 = '1; in_tag = 5'd12;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         #1;
         chk("stall out_valid", 64'(out_valid), 64'd1);
         chk("stall out_data", out_data, 64'd30);
         chk("stall in_ready", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("b2b in_ready", 64'(in_ready), 64'd1);
      chk("b2b old data", out_data, 64'd30);
      chk("b2b old tag", 64'(out_tag), 64'd3);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("b2b wait out_valid", 64'(out_valid), 64'd0);
      chk("b2b wait busy", 64'(busy), 64'd1);
      @(negedge clk);
      #1;
      chk("b2b new out_valid", 64'(out_valid), 64'd1);
      chk("b2b new data", out_data, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("b2b new tag", 64'(out_tag), 64'd12);
      @(negedge clk);
      #1 chk("b2b idle busy", 64'(busy), 64'd0);

      // Flush while waiting on the multiplier, with an op offered on the flush cycle.
      in_valid = 1'b1; in_op = 3'd0; in_src0 = 64'd2; in_src1 = 64'd2; in_tag = 5'd7;
      @(negedge clk);
      flush = 1'b1; in_src0 = 64'd9; in_tag = 5'd8;
      #1 chk("flushW in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("flushW busy", 64'(busy), 64'd0);
      chk("flushW out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      chk("flushW later out_valid", 64'(out_valid), 64'd0);
      chk("flushW later busy", 64'(busy), 64'd0);

      // Flush while the result is held in DONE.
      in_valid = 1'b1; in_op = 3'd0; in_src0 = 64'd3; in_src1 = 64'd3; in_tag = 5'd10;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1 chk("flushD busy", 64'(busy), 64'd1);
      flush = 1'b1; in_valid = 1'b1;
      #1 chk("flushD in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("flushD out_valid", 64'(out_valid), 64'd0);
      chk("flushD busy idle", 64'(busy), 64'd0);
      @(negedge clk);
      #1 chk("flushD later out_valid", 64'(out_valid), 64'd0);

      // Reset for one cycle while in WAIT.
      in_valid = 1'b1; in_op = 3'd1; in_src0 = 64'd11; in_src1 = 64'd13; in_tag = 5'd21;
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rstW out_valid", 64'(out_valid), 64'd0);
      chk("rstW out_data", out_data, 64'd0);
      chk("rstW out_tag", 64'(out_tag), 64'd0);
      chk("rstW busy", 64'(busy), 64'd0);
      chk("rstW in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      #1 chk("rstW later out_valid", 64'(out_valid), 64'd0);

      // A request fired during reset leaves a stray multiplier vld in IDLE.
      rst_n = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_src0 = 64'd4; in_src1 = 64'd4;
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("stray out_valid", 64'(out_valid), 64'd0);
      chk("stray busy", 64'(busy), 64'd0);
      @(negedge clk);
      #1 chk("stray later out_valid", 64'(out_valid), 64'd0);

      run_op("post", 3'd0, 64'd6, 64'd7, 5'd5, 64'd42, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
